serial_adder_sub: RTL and testbench

SERIAL_ADDER_SUB -- requirements
Module: serial_adder_sub

---
 rtl/serial_adder_sub.sv | 205 ++++++++++++++++++++
 tb/tb_serial_adder_sub.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_sub.sv
// serial_adder_sub: bit-serial (or slice-serial) adder/subtractor with
// valid/ready handshakes on both operand and result sides.
//
// An operation is accepted in IDLE, then processed BITS_PER_CYCLE bits per
// clock, LSB slice first, with the carry chained between slices. After
// WIDTH/BITS_PER_CYCLE cycles the result is registered and held in DONE
// until the consumer takes it.
//
// Ports:
//   clk        sole clock, rising edge
//   rstn       asynchronous active-low reset
//   in_valid   operands/mode valid          in_ready   block accepts operands
//   A, B       operands (WIDTH bits)        Ci         carry-in / borrow-in
//   Sub        0 = add, 1 = subtract
//   out_valid  result valid                 out_ready  consumer takes result
//   Sum        result (WIDTH bits)          Cout       raw carry out of MSB
//   Ovf        two's-complement overflow    busy       high while in RUN
module serial_adder_sub #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             busy
);

  localparam int BPC   = BITS_PER_CYCLE;
  localparam int N     = (BPC > 0) ? (WIDTH / BPC) : 1;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  // Elaboration-time parameter legality checks.
  if (WIDTH < 2) begin : g_bad_width
    $error("serial_adder_sub: WIDTH must be >= 2");
  end
  if ((BPC < 1) || (BPC > WIDTH) || ((WIDTH % BPC) != 0)) begin : g_bad_bpc
    $error("serial_adder_sub: BITS_PER_CYCLE must divide WIDTH exactly");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_finish;

  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;       // already inverted for subtract
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;     // result slices shifted in from the top

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [BPC:0]     w_slice;
  logic             w_c_msb_in;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [WIDTH-1:0] w_acc_nxt;

  // One slice of the addition, including its carry out in the top bit.
  assign w_slice = {1'b0, r_a[BPC-1:0]} + {1'b0, r_b[BPC-1:0]}
                 + {{BPC{1'b0}}, r_carry};

  // Carry into the slice MSB recovered from a ^ b ^ sum at that bit; on the
  // last slice this is the carry into the word MSB.
  assign w_c_msb_in = r_a[BPC-1] ^ r_b[BPC-1] ^ w_slice[BPC-1];

  // Operand shift and result assembly; a single-slice word needs no shifting.
  if (BPC == WIDTH) begin : g_one_slice
    assign w_a_nxt   = {WIDTH{1'b0}};
    assign w_b_nxt   = {WIDTH{1'b0}};
    assign w_acc_nxt = w_slice[BPC-1:0];
  end else begin : g_multi_slice
    assign w_a_nxt   = {{BPC{1'b0}}, r_a[WIDTH-1:BPC]};
    assign w_b_nxt   = {{BPC{1'b0}}, r_b[WIDTH-1:BPC]};
    assign w_acc_nxt = {w_slice[BPC-1:0], r_acc[WIDTH-1:BPC]};
  end

  // Next-state logic and handshake qualifiers.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_cnt == LAST) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (r_out_valid && out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and registered status outputs derived from next state,
  // so in_ready only rises on the first edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
      r_busy      <= (w_state_nxt == ST_RUN);
    end
  end

  // Operand capture on accept and slice-by-slice processing in RUN.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_carry <= 1'b0;
      r_cnt   <= {CNT_W{1'b0}};
      r_acc   <= {WIDTH{1'b0}};
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= B ^ {WIDTH{Sub}};
      r_carry <= Ci ^ Sub;
      r_cnt   <= {CNT_W{1'b0}};
      r_acc   <= {WIDTH{1'b0}};
    end else if (r_state == ST_RUN) begin
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_carry <= w_slice[BPC];
      r_cnt   <= r_cnt + CNT_W'(1);
      r_acc   <= w_acc_nxt;
    end else begin
      r_a     <= r_a;
      r_b     <= r_b;
      r_carry <= r_carry;
      r_cnt   <= r_cnt;
      r_acc   <= r_acc;
    end
  end

  // Result registers load only on the RUN -> DONE transition.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sum  <= {WIDTH{1'b0}};
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_finish) begin
      r_sum  <= w_acc_nxt;
      r_cout <= w_slice[BPC];
      r_ovf  <= w_slice[BPC] ^ w_c_msb_in;
    end else begin
      r_sum  <= r_sum;
      r_cout <= r_cout;
      r_ovf  <= r_ovf;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign Sum       = r_sum;
  assign Cout      = r_cout;
  assign Ovf       = r_ovf;

endmodule

// File: tb/tb_serial_adder_sub.sv
// Self-checking bench for serial_adder_sub: directed WIDTH=8 sequence plus
// exhaustive WIDTH=4 sweeps for BITS_PER_CYCLE 1, 2 and 4 with random
// out_ready back-pressure. Expected results come from a scoreboard queue.
module tb_serial_adder_sub;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic clk;
  logic rstn;

  // WIDTH=8, BITS_PER_CYCLE=1 instance
  logic       in_valid, in_ready, ci, sub, out_valid, out_ready, cout, ovf, busy;
  logic [7:0] a, b, sum;

  // WIDTH=4 instances, index 0/1/2 -> BITS_PER_CYCLE 1/2/4
  logic       v4[3], rdy4[3], ci4[3], sb4[3], ov4[3], or4[3], cout4[3], ovf4[3], busy4[3];
  logic [3:0] a4[3], b4[3], sum4[3];

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  serial_adder_sub #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Ci(ci), .Sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .Sum(sum), .Cout(cout), .Ovf(ovf), .busy(busy)
  );

  for (genvar g = 0; g < 3; g++) begin : g_w4
    serial_adder_sub #(.WIDTH(4), .BITS_PER_CYCLE(1 << g)) u_dut4 (
      .clk(clk), .rstn(rstn), .in_valid(v4[g]), .in_ready(rdy4[g]),
      .A(a4[g]), .B(b4[g]), .Ci(ci4[g]), .Sub(sb4[g]), .out_valid(ov4[g]),
      .out_ready(or4[g]), .Sum(sum4[g]), .Cout(cout4[g]), .Ovf(ovf4[g]),
      .busy(busy4[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: width-w add/subtract with signed overflow from operand signs.
  function automatic exp_t model(input int w, input logic [7:0] ma, input logic [7:0] mb,
                                 input logic mci, input logic msub);
    exp_t       e;
    logic [7:0] mask;
    logic [7:0] bx;
    logic [8:0] full;
    mask   = 8'((9'd1 << w) - 9'd1);
    bx     = (msub ? ~mb : mb) & mask;
    full   = {1'b0, ma & mask} + {1'b0, bx} + {8'd0, mci ^ msub};
    e.sum  = full[7:0] & mask;
    e.cout = full[w];
    e.ovf  = (ma[w-1] == bx[w-1]) && (e.sum[w-1] != ma[w-1]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation: accept, latency, result, optional DONE hold.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tci,
                     input logic tsub, input int hold, input logic rdy_early);
    exp_t e;
    int   lat;
    chk("op8_ready_before", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb_;
    ci        = tci;
    sub       = tsub;
    out_ready = rdy_early;
    tick();
    in_valid = 1'b0;
    sb_q.push_back(model(8, ta, tb_, tci, tsub));
    chk("op8_busy", {31'd0, busy}, 32'd1);
    chk("op8_not_ready", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 30) begin
      tick();
      lat++;
    end
    chk("op8_latency", lat, 32'd8);
    chk("op8_busy_done", {31'd0, busy}, 32'd0);
    e = sb_q.pop_front();
    chk("op8_sum", {24'd0, sum}, {24'd0, e.sum});
    chk("op8_cout", {31'd0, cout}, {31'd0, e.cout});
    chk("op8_ovf", {31'd0, ovf}, {31'd0, e.ovf});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'(i % 2 == 0);
      a        = ~a;
      tick();
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_res", {22'd0, sum, cout, ovf}, {22'd0, e.sum, e.cout, e.ovf});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("op8_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("op8_hs_ready", {31'd0, in_ready}, 32'd1);
  endtask

  // Exhaustive sweep of one WIDTH=4 instance.
  task automatic ex_run(input int c);
    exp_t e;
    int   lat;
    int   w;
    int   n;
    n = 4 >> c;
    for (int op = 0; op < 1024; op++) begin
      v4[c]  = 1'b1;
      a4[c]  = op[3:0];
      b4[c]  = op[7:4];
      ci4[c] = op[8];
      sb4[c] = op[9];
      w = 0;
      while (!rdy4[c] && w < 20) begin
        tick();
        w++;
      end
      tick();
      v4[c] = 1'b0;
      sb_q.push_back(model(4, {4'd0, op[3:0]}, {4'd0, op[7:4]}, op[8], op[9]));
      lat = 1;
      or4[c] = 1'($urandom_range(0, 1));
      while (!ov4[c] && lat < 20) begin
        tick();
        if (!ov4[c]) lat++;
        else lat = lat;
        or4[c] = 1'($urandom_range(0, 1));
      end
      chk($sformatf("ex_lat c%0d op%0d", c, op), lat, n);
      e = sb_q.pop_front();
      chk($sformatf("ex_res c%0d op%0d", c, op), {26'd0, sum4[c], cout4[c], ovf4[c]},
          {26'd0, e.sum[3:0], e.cout, e.ovf});
      w = 0;
      while (ov4[c] && w < 40) begin
        or4[c] = 1'($urandom_range(0, 1));
        tick();
        w++;
      end
      or4[c] = 1'b0;
      chk($sformatf("ex_hs c%0d op%0d", c, op), {30'd0, ov4[c], rdy4[c]}, 32'd1);
    end
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'd0; b = 8'd0; ci = 1'b0; sub = 1'b0;
    for (int g = 0; g < 3; g++) begin
      v4[g] = 1'b0; or4[g] = 1'b0; a4[g] = 4'd0; b4[g] = 4'd0; ci4[g] = 1'b0; sb4[g] = 1'b0;
    end
    #1;
    chk("rst_outputs", {20'd0, in_ready, out_valid, busy, sum, cout, ovf}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_ready_before_edge", {31'd0, in_ready}, 32'd0);
    tick();
    chk("rst_ready_after_edge", {31'd0, in_ready}, 32'd1);

    op8(8'h0F, 8'h01, 1'b0, 1'b0, 0, 1'b0);
    op8(8'h7F, 8'h01, 1'b0, 1'b0, 0, 1'b1);
    op8(8'hFF, 8'h01, 1'b1, 1'b0, 0, 1'b0);
    op8(8'h05, 8'h07, 1'b0, 1'b1, 0, 1'b1);
    op8(8'h80, 8'h01, 1'b0, 1'b1, 5, 1'b0);
    op8(8'h3C, 8'h5A, 1'b1, 1'b1, 0, 1'b0);

    // Reset during the third RUN cycle.
    in_valid = 1'b1; a = 8'h12; b = 8'h34; ci = 1'b0; sub = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_run_busy", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_outputs", {20'd0, in_ready, out_valid, busy, sum, cout, ovf}, 32'd0);
    repeat (2) tick();
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("mid_rst_ready_before", {31'd0, in_ready}, 32'd0);
    tick();
    chk("mid_rst_ready_after", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mid_rst_no_output", {30'd0, out_valid, busy}, 32'd0);
    end
    op8(8'hA5, 8'h5B, 1'b1, 1'b0, 0, 1'b0);

    for (int c = 0; c < 3; c++) ex_run(c);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
